// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: shares one fixed-latency memory between the
// fetch (IF) and load/store (MEM) requesters, with round-robin tie breaking.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                srv_dm_q, srv_dm_d;
  logic                last_dm_q, last_dm_d;
  logic                kill_q, kill_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic                busy_q, busy_d;

  logic                elig_if, elig_dm, pick_dm;

  // Eligibility: in RESP the served requester is excluded, unless it was a
  // killed fetch whose if_req now carries a fresh request.
  always_comb begin
    elig_if = 1'b0;
    elig_dm = 1'b0;
    if (state_q == ST_IDLE) begin
      elig_if = if_req;
      elig_dm = dm_req;
    end else if (state_q == ST_RESP) begin
      elig_if = if_req & (srv_dm_q | kill_q);
      elig_dm = dm_req & ~srv_dm_q;
    end
    pick_dm = elig_dm & (~elig_if | ~last_dm_q);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    srv_dm_d    = srv_dm_q;
    last_dm_d   = last_dm_q;
    kill_d      = kill_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (elig_if | elig_dm) begin
          state_d  = ST_ACCESS;
          cnt_d    = '0;
          srv_dm_d = pick_dm;
          kill_d   = 1'b0;
          mem_en_d = 1'b1;
          // Round-robin pointer only moves on a genuine tie.
          if (elig_if & elig_dm) begin
            last_dm_d = pick_dm;
          end
          if (pick_dm) begin
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
          end
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      ST_ACCESS: begin
        kill_d = kill_q | (if_kill & ~srv_dm_q);
        if (srv_dm_q & mem_we_q) begin
          state_d    = ST_RESP;
          dm_ready_d = 1'b1;
        end else if (cnt_q == LAT_LAST) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          if (srv_dm_q) begin
            dm_rdata_d = mem_rdata;
            dm_ready_d = 1'b1;
          end else if (!(kill_q | if_kill)) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      srv_dm_q    <= 1'b0;
      last_dm_q   <= 1'b0;
      kill_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      srv_dm_q    <= srv_dm_d;
      last_dm_q   <= last_dm_d;
      kill_q      <= kill_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_ready  = dm_ready_q;
  assign busy      = busy_q;

  // Pipeline stall requests; held low while reset is asserted.
  assign stall_if  = rstn & if_req & ~if_ready_q & ~if_kill;
  assign stall_mem = rstn & dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed timing scenarios plus random
// fetch/load/store traffic checked against a word-array memory model.
module tb_mem_arbiter;

  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int          BOUND   = 20;

  logic          clk = 1'b0;
  logic          rstn;
  logic          if_req, if_kill, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic          if_ready, dm_ready, mem_en, mem_we, stall_if, stall_mem, busy;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int k = 0;

  function automatic logic [31:0] init_val(input int w);
    if (w == 16) return 32'h00500093;
    return 32'hC0DE0000 + 32'(w) * 32'd4099;
  endfunction

  // Memory model: written words override the initial image; reads appear
  // MEM_LAT cycles after the issue cycle, garbage otherwise.
  bit            wv [1024];
  logic [31:0]   wd [1024];
  logic [31:0]   rd_sr [MEM_LAT];
  logic          rv_sr [MEM_LAT] = '{default: 1'b0};

  assign mem_rdata = rv_sr[MEM_LAT-1] ? rd_sr[MEM_LAT-1] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wv[mem_addr[11:2]] <= 1'b1;
      wd[mem_addr[11:2]] <= mem_wdata;
    end
    rd_sr[0] <= wv[mem_addr[11:2]] ? wd[mem_addr[11:2]] : init_val(int'(mem_addr[11:2]));
    rv_sr[0] <= mem_en && !mem_we;
    for (int i = 1; i < MEM_LAT; i++) begin
      rd_sr[i] <= rd_sr[i-1];
      rv_sr[i] <= rv_sr[i-1];
    end
  end

  // Reference model and scoreboard queues.
  logic [31:0] ref_mem [1024];
  logic [31:0] ref_dm_last;
  logic [31:0] if_q [$];
  logic [31:0] dm_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    if_q.push_back(ref_mem[a[11:2]]);
  endtask

  task automatic push_load(input logic [31:0] a);
    ref_dm_last = ref_mem[a[11:2]];
    dm_q.push_back(ref_dm_last);
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d);
    ref_mem[a[11:2]] = d;
    dm_q.push_back(ref_dm_last);
  endtask

  // Monitor: every ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rstn) begin
      if (if_ready) begin
        if (if_q.size() == 0) chk("if_ready_unexpected", 32'(if_ready), 32'd0);
        else chk("if_rdata", if_rdata, if_q.pop_front());
      end
      if (dm_ready) begin
        if (dm_q.size() == 0) chk("dm_ready_unexpected", 32'(dm_ready), 32'd0);
        else chk("dm_rdata", dm_rdata, dm_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    if_req = 0; if_kill = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    rstn = 1'b1;
    ref_dm_last = '0;
    k = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
    k++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk($sformatf("%s_mem_en@%0d", tag, k), 32'(mem_en), 32'd0);
    chk($sformatf("%s_mem_we@%0d", tag, k), 32'(mem_we), 32'd0);
    chk($sformatf("%s_mem_addr@%0d", tag, k), mem_addr, 32'd0);
    chk($sformatf("%s_mem_wdata@%0d", tag, k), mem_wdata, 32'd0);
    chk($sformatf("%s_if_rdata@%0d", tag, k), if_rdata, 32'd0);
    chk($sformatf("%s_dm_rdata@%0d", tag, k), dm_rdata, 32'd0);
    chk($sformatf("%s_if_ready@%0d", tag, k), 32'(if_ready), 32'd0);
    chk($sformatf("%s_dm_ready@%0d", tag, k), 32'(dm_ready), 32'd0);
    chk($sformatf("%s_busy@%0d", tag, k), 32'(busy), 32'd0);
  endtask

  task automatic agent_if(input int n);
    for (int t = 0; t < n; t++) begin
      int gap;
      bit done;
      int w;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      if_addr = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
      if_req  = 1'b1;
      push_fetch(if_addr);
      done = 0; w = 0;
      while (!done && w < BOUND) begin
        @(negedge clk);
        if (if_ready) done = 1;
        else w++;
      end
      chk("if_timeout", 32'(done), 32'd1);
      @(posedge clk); #1;
      if_req = 1'b0;
    end
  endtask

  task automatic agent_dm(input int n);
    for (int t = 0; t < n; t++) begin
      int gap;
      bit done;
      int w;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      dm_addr  = {22'h0, 2'b01, 6'($urandom_range(0, 63)), 2'b00};
      dm_we    = 1'($urandom_range(0, 1));
      dm_wdata = $urandom;
      dm_req   = 1'b1;
      if (dm_we) push_store(dm_addr, dm_wdata);
      else push_load(dm_addr);
      done = 0; w = 0;
      while (!done && w < BOUND) begin
        @(negedge clk);
        if (dm_ready) done = 1;
        else w++;
      end
      chk("dm_timeout", 32'(done), 32'd1);
      @(posedge clk); #1;
      dm_req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    idle_inputs();
    ref_dm_last = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    do_reset();
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset_stall_if", 32'(stall_if), 32'd0);

    // Lone fetch.
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      if_req  = (k <= 5);
      if_addr = 32'h40;
      if (k == 1) push_fetch(32'h40);
      @(negedge clk);
      chk($sformatf("t1_mem_en@%0d", k), 32'(mem_en), 32'(k == 2));
      chk($sformatf("t1_if_ready@%0d", k), 32'(if_ready), 32'(k == 5));
      chk($sformatf("t1_stall_if@%0d", k), 32'(stall_if), 32'(k >= 1 && k <= 4));
      chk($sformatf("t1_busy@%0d", k), 32'(busy), 32'(k >= 2 && k <= 5));
    end

    // Store then load of the same word.
    k = 0;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      dm_req   = (k <= 8);
      dm_we    = (k <= 3);
      dm_addr  = 32'h100;
      dm_wdata = 32'hDEADBEEF;
      if (k == 1) push_store(32'h100, 32'hDEADBEEF);
      if (k == 4) push_load(32'h100);
      @(negedge clk);
      chk($sformatf("t2_mem_en@%0d", k), 32'(mem_en), 32'(k == 2 || k == 5));
      chk($sformatf("t2_mem_we@%0d", k), 32'(mem_en & mem_we), 32'(k == 2));
      chk($sformatf("t2_dm_ready@%0d", k), 32'(dm_ready), 32'(k == 3 || k == 8));
      if (k == 2) begin
        chk("t2_mem_addr", mem_addr, 32'h100);
        chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
      end
    end

    // Simultaneous requests: first tie to data, second tie to fetch.
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      if_req  = (k <= 9) || (k >= 11 && k <= 15);
      if_addr = (k <= 10) ? 32'h40 : 32'h80;
      dm_req  = (k <= 5) || (k >= 11 && k <= 19);
      dm_we   = 1'b0;
      dm_addr = (k <= 10) ? 32'h100 : 32'h104;
      if (k == 1) begin push_fetch(32'h40); push_load(32'h100); end
      if (k == 11) begin push_fetch(32'h80); push_load(32'h104); end
      @(negedge clk);
      chk($sformatf("t3_mem_en@%0d", k), 32'(mem_en),
          32'(k == 2 || k == 6 || k == 12 || k == 16));
      chk($sformatf("t3_if_ready@%0d", k), 32'(if_ready), 32'(k == 9 || k == 15));
      chk($sformatf("t3_dm_ready@%0d", k), 32'(dm_ready), 32'(k == 5 || k == 19));
    end

    // Killed fetch followed by a new fetch granted from RESP.
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if_req  = (k <= 9);
      if_addr = (k <= 3) ? 32'h40 : 32'h80;
      if_kill = (k == 3);
      if (k == 4) push_fetch(32'h80);
      @(negedge clk);
      chk($sformatf("t4_if_ready@%0d", k), 32'(if_ready), 32'(k == 9));
      chk($sformatf("t4_mem_en@%0d", k), 32'(mem_en), 32'(k == 2 || k == 6));
      chk($sformatf("t4_busy@%0d", k), 32'(busy), 32'(k >= 2 && k <= 9));
      if (k == 3) chk("t4_stall_if_kill", 32'(stall_if), 32'd0);
      if (k >= 5 && k <= 8) chk($sformatf("t4_if_rdata_hold@%0d", k), if_rdata, 32'd0);
      if (k == 6) chk("t4_mem_addr", mem_addr, 32'h80);
    end
    if_kill = 1'b0;

    // Reset in the middle of a load.
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      rstn     = (k != 6);
      dm_req   = (k <= 6);
      dm_we    = (k <= 3);
      dm_addr  = (k <= 3) ? 32'h108 : 32'h104;
      dm_wdata = 32'h55AA55AA;
      if (k == 1) push_store(32'h108, 32'h55AA55AA);
      if (k == 6) ref_dm_last = '0;
      @(negedge clk);
      chk($sformatf("t5_dm_ready@%0d", k), 32'(dm_ready), 32'(k == 3));
      if (k == 5) chk("t5_mem_addr_pre", mem_addr, 32'h104);
      if (k == 6) chk("t5_stall_mem_rst", 32'(stall_mem), 32'd0);
      if (k >= 7) chk_all_zero("t5");
    end
    rstn   = 1'b1;
    dm_req = 1'b0;

    // Address change after issue is ignored.
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      dm_req  = (k <= 5);
      dm_we   = 1'b0;
      dm_addr = (k <= 2) ? 32'h100 : 32'h200;
      if (k == 1) push_load(32'h100);
      @(negedge clk);
      chk($sformatf("t6_dm_ready@%0d", k), 32'(dm_ready), 32'(k == 5));
      if (k >= 2) chk($sformatf("t6_mem_addr@%0d", k), mem_addr, 32'h100);
    end

    // Random concurrent traffic.
    do_reset();
    fork
      agent_if(40);
      agent_dm(40);
    join
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("if_q_drained", 32'(if_q.size()), 32'd0);
    chk("dm_q_drained", 32'(dm_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
